mul_div_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers, parametrised in datapath width.
- Used as the execute-stage companion of the next-generation CPU to support MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Uses a start/busy/done handshake so the CPU can stall while the unit works.
- A radix-2 shift-add/restoring-divide datapath is shared by all four operations.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_iter_step.sv | 38 +++
 rtl/mul_div_unit.sv | 140 ++++++++++++++
 tb/tb_mul_div_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states and small operation-decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } state_e;

  function automatic logic is_div_op(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational radix-2 step: shift-add for multiply, restoring
// trial-subtract for divide, over a shared {acc_hi, acc_lo} register pair.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    // NOTE: every output is assigned on every path, so no latch is inferred.
    if (is_div) begin
      // The partial remainder stays below the divisor, so trial's MSB is a clean borrow.
      if (trial[WIDTH]) begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
        nxt_hi = trial[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and a
// start/busy/done handshake; operates on magnitudes and fixes signs at the end.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             neg_lo, neg_hi, dz_q;

  op_e              op_in;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0] quo_res, rem_res;

  assign op_in = op_e'(op_i);
  assign s1    = is_signed_op(op_in) & src1_i[WIDTH-1];
  assign s2    = is_signed_op(op_in) & src2_i[WIDTH-1];
  assign mag1  = s1 ? -src1_i : src1_i;
  assign mag2  = s2 ? -src2_i : src2_i;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_op(op_q)),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // Negating the magnitude of MIN wraps back to MIN, which gives MIN/-1 = MIN.
  assign prod_mag = {acc_hi, acc_lo};
  assign prod_res = neg_lo ? -prod_mag : prod_mag;
  assign quo_res  = neg_lo ? -acc_lo : acc_lo;
  assign rem_res  = neg_hi ? -acc_hi : acc_hi;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_MULT;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd       <= '0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      dz_q       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
    end else begin
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q   <= op_in;
            cnt    <= '0;
            acc_hi <= '0;
            busy_o <= 1'b1;
            neg_lo <= s1 ^ s2;
            if (is_div_op(op_in)) begin
              opnd   <= mag2;
              neg_hi <= s1;
              if (src2_i == '0) begin
                acc_lo <= src1_i;
                dz_q   <= 1'b1;
                state  <= FIXUP;
              end else begin
                acc_lo <= mag1;
                dz_q   <= 1'b0;
                state  <= RUN;
              end
            end else begin
              opnd   <= mag1;
              acc_lo <= mag2;
              neg_hi <= s1 ^ s2;
              dz_q   <= 1'b0;
              state  <= RUN;
            end
          end else begin
            if (hi_we_i) hi_o <= wdata_i;
            if (lo_we_i) lo_o <= wdata_i;
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          if (dz_q) begin
            hi_o <= acc_lo;
            lo_o <= '1;
          end else if (is_div_op(op_q)) begin
            hi_o <= rem_res;
            lo_o <= quo_res;
          end else begin
            hi_o <= prod_res[2*WIDTH-1:WIDTH];
            lo_o <= prod_res[WIDTH-1:0];
          end
          busy_o     <= 1'b0;
          done_o     <= 1'b1;
          div_zero_o <= dz_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32) with
// hand-computed HI/LO results, latency and handshake checks.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src1, src2, wdata;
  logic         hi_we, lo_we;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .op_i       (op),
    .src1_i     (src1),
    .src2_i     (src2),
    .hi_we_i    (hi_we),
    .lo_we_i    (lo_we),
    .wdata_i    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Called just after an edge; returns cycles sampled until done_o (bounded).
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dz, input int exp_lat);
    int cyc, bcnt;
    launch(o, a, b);
    wait_done(cyc, bcnt);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc, bcnt, done_seen;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    run_op("mult_neg",  2'b00, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
    run_op("multu_2p32", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0, 33);
    run_op("div_neg",   2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("div_negdv", 2'b10, 32'd7, -32'sd2, 32'h1, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("divu",      2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    run_op("div_minm1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("div_zero_neg", 2'b10, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1);

    // Re-pulse start at E0+5 with other operands: must be ignored.
    launch(2'b01, 32'd6, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'b11; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    check("repulse_lat", 64'(cyc), 64'd28);
    check("repulse_hi", 64'(hi), 64'd0);
    check("repulse_lo", 64'(lo), 64'd42);
    @(posedge clk); #1;

    // Reset at E0+10 aborts the operation.
    launch(2'b01, 32'd3, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) done_seen++; end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // MTHI / MTLO while idle.
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1; hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_lo", 64'(lo), 64'h0);
    @(negedge clk); lo_we = 1'b1; wdata = 32'h55;
    @(posedge clk); #1; lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h55);
    check("mtlo_hi", 64'(hi), 64'h1234);
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    check("mtboth_hi", 64'(hi), 64'hABCD);
    check("mtboth_lo", 64'(lo), 64'hABCD);

    // Write in the same cycle as start, then while busy: both ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b01; src1 = 32'd2; src2 = 32'd3; hi_we = 1'b1; wdata = 32'h7777;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("mthi_at_start", 64'(hi), 64'hABCD);
    @(negedge clk); hi_we = 1'b1; wdata = 32'h9999;
    @(posedge clk); #1; hi_we = 1'b0;
    check("mthi_busy", 64'(hi), 64'hABCD);
    wait_done(cyc, bcnt);
    check("mthi_op_lat", 64'(cyc), 64'd32);
    check("mthi_op_hi", 64'(hi), 64'd0);
    check("mthi_op_lo", 64'(lo), 64'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
